// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//  Instruction-fetch stage that sits upstream of the hazard/control logic.
//  It owns the PC, the next-PC mux and the IF/ID pipeline register. It fetches
//  over a req/ready instruction-memory port and copes with multi-cycle memory
//  waits. A word that arrives while the pipe is stalled is captured in a hold
//  buffer. A redirect that lands while a fetch is still outstanding is also
//  handled: the stale response is drained and thrown away.
//
// Ports
//  Clk, Rst             clock and synchronous active-high reset
//  PC_Write, IF_Write   hazard-unit enables for the PC and IF/ID register
//  addrSel              next-PC select (00 PC+4, 01 jump, 10 branch, 11 = 00)
//  IF_Flush             clear IF/ID to a bubble; overrides IF_Write
//  JumpTarget           jump destination from ID
//  BranchTarget         branch destination from EX
//  imem_req/imem_addr   fetch request and its address (address is stable while waiting)
//  imem_ready/imem_rdata  response strobe and the fetched word
//  pc                   current PC
//  ifid_instr/ifid_pc4/ifid_valid  IF/ID register contents
//  fetch_stall          high when no instruction is available this cycle
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PC_Write,
  input  logic        IF_Write,
  input  logic [1:0]  addrSel,
  input  logic        IF_Flush,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_stall
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_reqAddr;
  logic [31:0] r_holdBuf;
  logic [31:0] r_ifidInstr;
  logic [31:0] r_ifidPc4;
  logic        r_ifidValid;

  logic        w_avail;
  logic [31:0] w_word;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_advance;
  logic [31:0] w_pcPlus4;

  // A word is available when the memory answers a live fetch, or when one was
  // parked earlier in the hold buffer. DISCARD responses are never usable.
  assign w_avail    = ((r_state == S_FETCH) && imem_ready) || (r_state == S_HOLD);
  assign w_word     = (r_state == S_HOLD) ? r_holdBuf : imem_rdata;
  assign w_redirect = PC_Write && ((addrSel == 2'b01) || (addrSel == 2'b10));
  assign w_target   = (addrSel == 2'b01) ? JumpTarget : BranchTarget;
  assign w_advance  = PC_Write && IF_Write && w_avail && !w_redirect;
  assign w_pcPlus4  = r_pc + 32'd4;

  assign imem_req    = (r_state != S_HOLD);
  assign imem_addr   = r_reqAddr;
  assign pc          = r_pc;
  assign ifid_instr  = r_ifidInstr;
  assign ifid_pc4    = r_ifidPc4;
  assign ifid_valid  = r_ifidValid;
  assign fetch_stall = !w_avail;

  // PC: a redirect wins even when no word is available.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_advance) begin
      r_pc <= w_pcPlus4;
    end
  end

  // IF/ID register. A bubble keeps the old pc4 because it is meaningless while
  // valid is low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ifidInstr <= NOP_INSTR;
      r_ifidPc4   <= 32'd0;
      r_ifidValid <= 1'b0;
    end else if (IF_Flush) begin
      r_ifidInstr <= NOP_INSTR;
      r_ifidValid <= 1'b0;
    end else if (IF_Write && w_avail && !w_redirect) begin
      r_ifidInstr <= w_word;
      r_ifidPc4   <= w_pcPlus4;
      r_ifidValid <= 1'b1;
    end else if (IF_Write) begin
      r_ifidInstr <= NOP_INSTR;
      r_ifidValid <= 1'b0;
    end
  end

  // Fetch FSM. The memory address must stay put while a request is pending.
  // After a redirect mid-wait we therefore keep requesting the stale address
  // in DISCARD until the memory answers. Only then do we move on to the new pc.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_FETCH;
      r_reqAddr <= RESET_PC;
      r_holdBuf <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            if (w_redirect) begin
              r_reqAddr <= w_target;
            end else if (w_advance) begin
              r_reqAddr <= w_pcPlus4;
            end else begin
              r_state   <= S_HOLD;
              r_holdBuf <= imem_rdata;
            end
          end else if (w_redirect) begin
            r_state <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_state   <= S_FETCH;
            r_reqAddr <= w_target;
          end else if (w_advance) begin
            r_state   <= S_FETCH;
            r_reqAddr <= w_pcPlus4;
          end
        end
        S_DISCARD: begin
          if (imem_ready) begin
            r_state   <= S_FETCH;
            r_reqAddr <= w_redirect ? w_target : r_pc;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//  Directed bench for if_fetch_stage. Each cycle drives one set of inputs and
//  pushes the outputs expected for that cycle onto a scoreboard queue. Once the
//  combinational logic has settled, the bench pops the entry and compares it
//  against the DUT. The instruction memory returns addr ^ 32'h1357_9BDF so that
//  every fetched word can be traced back to its address.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        chkPc4;
    logic        valid;
  } expT;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PC_Write;
  logic        IF_Write;
  logic [1:0]  addrSel;
  logic        IF_Flush;
  logic [31:0] JumpTarget;
  logic [31:0] BranchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_stall;

  expT sbQueue[$];
  int  nVec  = 0;
  int  nFail = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0000;

  assign imem_rdata = imem_ready ? memWord(imem_addr) : 32'hDEAD_BEEF;

  always #5 Clk = ~Clk;

  if_fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .PC_Write(PC_Write), .IF_Write(IF_Write),
    .addrSel(addrSel), .IF_Flush(IF_Flush), .JumpTarget(JumpTarget),
    .BranchTarget(BranchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_stall(fetch_stall)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int cyc);
    expT e;
    if (sbQueue.size() == 0) begin
      nVec++;
      nFail++;
      $error("[TB] FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc);
      return;
    end
    e = sbQueue.pop_front();
    check32($sformatf("c%0d pc", cyc), pc, e.pc);
    check32($sformatf("c%0d imem_req", cyc), {31'd0, imem_req}, {31'd0, e.req});
    check32($sformatf("c%0d imem_addr", cyc), imem_addr, e.addr);
    check32($sformatf("c%0d fetch_stall", cyc), {31'd0, fetch_stall}, {31'd0, e.stall});
    check32($sformatf("c%0d ifid_instr", cyc), ifid_instr, e.instr);
    check32($sformatf("c%0d ifid_valid", cyc), {31'd0, ifid_valid}, {31'd0, e.valid});
    if (e.chkPc4) check32($sformatf("c%0d ifid_pc4", cyc), ifid_pc4, e.pc4);
  endtask

  // Drive one cycle at the falling edge, check once settled, then let the
  // rising edge commit it.
  task automatic applyStimulus(
    input int cyc, input logic rst, input logic pcw, input logic ifw,
    input logic [1:0] sel, input logic flush, input logic rdy,
    input logic [31:0] jt, input logic [31:0] bt,
    input logic [31:0] ePc, input logic eReq, input logic [31:0] eAddr,
    input logic eStall, input logic [31:0] eInstr, input logic [31:0] ePc4,
    input logic eChk4, input logic eValid);
    expT e;
    e.pc = ePc; e.req = eReq; e.addr = eAddr; e.stall = eStall;
    e.instr = eInstr; e.pc4 = ePc4; e.chkPc4 = eChk4; e.valid = eValid;
    sbQueue.push_back(e);
    Rst = rst; PC_Write = pcw; IF_Write = ifw; addrSel = sel; IF_Flush = flush;
    imem_ready = rdy; JumpTarget = jt; BranchTarget = bt;
    #1;
    checkOutput(cyc);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1; PC_Write = 1'b0; IF_Write = 1'b0; addrSel = 2'b00; IF_Flush = 1'b0;
    imem_ready = 1'b0; JumpTarget = 32'h0; BranchTarget = 32'h0;
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk);

    // Streaming fetch from reset; addrSel=11 in cycle 3 behaves like PC+4.
    applyStimulus(1, 0,1,1,2'b00,0,1, 0,0, 32'h0,1,32'h0,0, NOP,32'h0,1,0);
    applyStimulus(2, 0,1,1,2'b00,0,1, 0,0, 32'h4,1,32'h4,0, memWord(32'h0),32'h4,1,1);
    applyStimulus(3, 0,1,1,2'b11,0,1, 32'h111,32'h222, 32'h8,1,32'h8,0, memWord(32'h4),32'h8,1,1);
    applyStimulus(4, 0,1,1,2'b00,0,1, 0,0, 32'hC,1,32'hC,0, memWord(32'h8),32'hC,1,1);
    // Load stall: the word for 0x10 is held, then consumed without a refetch.
    applyStimulus(5, 0,0,0,2'b00,0,1, 0,0, 32'h10,1,32'h10,0, memWord(32'hC),32'h10,1,1);
    applyStimulus(6, 0,1,1,2'b00,0,1, 0,0, 32'h10,0,32'h10,0, memWord(32'hC),32'h10,1,1);
    // Jump with IF_Write=0: IF/ID keeps its contents.
    applyStimulus(7, 0,1,0,2'b01,0,1, 32'h400,0, 32'h14,1,32'h14,0, memWord(32'h10),32'h14,1,1);
    applyStimulus(8, 0,1,1,2'b00,0,1, 0,0, 32'h400,1,32'h400,0, memWord(32'h10),32'h14,1,1);
    // Two-cycle memory wait produces bubbles.
    applyStimulus(9, 0,1,1,2'b00,0,0, 0,0, 32'h404,1,32'h404,1, memWord(32'h400),32'h404,1,1);
    applyStimulus(10,0,1,1,2'b00,0,0, 0,0, 32'h404,1,32'h404,1, NOP,32'h0,0,0);
    applyStimulus(11,0,1,1,2'b00,0,1, 0,0, 32'h404,1,32'h404,0, NOP,32'h0,0,0);
    // Branch redirect during a wait: DISCARD drains the stale 0x408 fetch.
    applyStimulus(12,0,1,1,2'b10,0,0, 0,32'h80, 32'h408,1,32'h408,1, memWord(32'h404),32'h408,1,1);
    applyStimulus(13,0,1,1,2'b00,0,0, 0,0, 32'h80,1,32'h408,1, NOP,32'h0,0,0);
    applyStimulus(14,0,1,1,2'b00,0,0, 0,0, 32'h80,1,32'h408,1, NOP,32'h0,0,0);
    applyStimulus(15,0,1,1,2'b00,0,1, 0,0, 32'h80,1,32'h408,1, NOP,32'h0,0,0);
    applyStimulus(16,0,1,1,2'b00,0,1, 0,0, 32'h80,1,32'h80,0, NOP,32'h0,0,0);
    applyStimulus(17,0,1,1,2'b00,0,1, 0,0, 32'h84,1,32'h84,0, memWord(32'h80),32'h84,1,1);
    // Flush while stalled: IF/ID is cleared and the word goes to the hold buffer.
    applyStimulus(18,0,0,0,2'b00,1,1, 0,0, 32'h88,1,32'h88,0, memWord(32'h84),32'h88,1,1);
    applyStimulus(19,0,1,1,2'b00,0,0, 0,0, 32'h88,0,32'h88,0, NOP,32'h0,0,0);
    // Jump mid-wait, then a branch in the same cycle the stale response lands.
    applyStimulus(20,0,1,1,2'b01,0,0, 32'h200,0, 32'h8C,1,32'h8C,1, memWord(32'h88),32'h8C,1,1);
    applyStimulus(21,0,1,1,2'b10,0,1, 0,32'h300, 32'h200,1,32'h8C,1, NOP,32'h0,0,0);
    applyStimulus(22,0,1,1,2'b00,0,1, 0,0, 32'h300,1,32'h300,0, NOP,32'h0,0,0);
    // Reset while in DISCARD.
    applyStimulus(23,0,1,1,2'b10,0,0, 0,32'h500, 32'h304,1,32'h304,1, memWord(32'h300),32'h304,1,1);
    applyStimulus(24,1,1,1,2'b00,0,0, 0,0, 32'h500,1,32'h304,1, NOP,32'h0,0,0);
    applyStimulus(25,0,1,1,2'b00,0,1, 0,0, 32'h0,1,32'h0,0, NOP,32'h0,1,0);
    // PC wrap at the top of the address space.
    applyStimulus(26,0,1,0,2'b01,0,1, 32'hFFFF_FFFC,0, 32'h4,1,32'h4,0, memWord(32'h0),32'h4,1,1);
    applyStimulus(27,0,1,1,2'b00,0,1, 0,0, 32'hFFFF_FFFC,1,32'hFFFF_FFFC,0, memWord(32'h0),32'h4,1,1);
    // PC_Write=1 with IF_Write=0 and addrSel=00 holds the PC.
    applyStimulus(28,0,1,0,2'b00,0,1, 0,0, 32'h0,1,32'h0,0, memWord(32'hFFFF_FFFC),32'h0,1,1);
    applyStimulus(29,0,0,0,2'b00,0,1, 0,0, 32'h0,0,32'h0,0, memWord(32'hFFFF_FFFC),32'h0,1,1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
